// File: rtl/regfile_alu_pipe.sv
// ============================================================================
// Module   : regfile_alu_pipe
// Brief    : Two-stage register file + ALU with full result bypass.
// Revision : 1.0
// ============================================================================
`default_nettype none

module regfile_alu_pipe #(
  parameter int WIDTH      = 16,
  parameter int REG_ADDR_W = 4
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  In_valid,
  input  logic [REG_ADDR_W-1:0] RdestRegLoc,
  input  logic [REG_ADDR_W-1:0] RsrcRegLoc,
  input  logic                  Imm_s,
  input  logic [WIDTH-1:0]      Imm,
  input  logic [4:0]            OpCode,
  output logic                  Out_valid,
  output logic [WIDTH-1:0]      Result,
  output logic [4:0]            Flags
);

  localparam int NREGS = 2 ** REG_ADDR_W;

  localparam logic [4:0] OP_ADD = 5'h00;
  localparam logic [4:0] OP_SUB = 5'h01;
  localparam logic [4:0] OP_CMP = 5'h02;
  localparam logic [4:0] OP_AND = 5'h03;
  localparam logic [4:0] OP_OR  = 5'h04;
  localparam logic [4:0] OP_XOR = 5'h05;
  localparam logic [4:0] OP_MOV = 5'h06;
  localparam logic [4:0] OP_LSH = 5'h07;

  localparam int FLAG_N = 4;
  localparam int FLAG_Z = 3;
  localparam int FLAG_F = 2;
  localparam int FLAG_L = 1;
  localparam int FLAG_C = 0;

  logic [WIDTH-1:0]      regs [NREGS];

  logic                  s1_valid;
  logic [REG_ADDR_W-1:0] s1_dest;
  logic [4:0]            s1_op;
  logic [WIDTH-1:0]      s1_a;
  logic [WIDTH-1:0]      s1_b;

  logic [WIDTH:0]        sum;
  logic [WIDTH:0]        diff;
  logic [WIDTH-1:0]      alu_res;
  logic [4:0]            alu_flags;
  logic                  alu_wr;

  logic                  a_byp;
  logic                  b_byp;
  logic [WIDTH-1:0]      op_a;
  logic [WIDTH-1:0]      op_b;

  assign sum  = {1'b0, s1_a} + {1'b0, s1_b};
  assign diff = {1'b0, s1_a} - {1'b0, s1_b};

  always_comb begin
    alu_res   = '0;
    alu_flags = Flags;
    alu_wr    = 1'b0;
    case (s1_op)
      OP_ADD: begin
        alu_res           = sum[WIDTH-1:0];
        alu_wr            = 1'b1;
        alu_flags[FLAG_C] = sum[WIDTH];
        alu_flags[FLAG_F] = (s1_a[WIDTH-1] == s1_b[WIDTH-1]) && (sum[WIDTH-1] != s1_a[WIDTH-1]);
        alu_flags[FLAG_Z] = (sum[WIDTH-1:0] == '0);
      end
      OP_SUB: begin
        alu_res           = diff[WIDTH-1:0];
        alu_wr            = 1'b1;
        alu_flags[FLAG_C] = diff[WIDTH];
        alu_flags[FLAG_F] = (s1_a[WIDTH-1] != s1_b[WIDTH-1]) && (diff[WIDTH-1] != s1_a[WIDTH-1]);
        alu_flags[FLAG_Z] = (diff[WIDTH-1:0] == '0);
      end
      OP_CMP: begin
        alu_res           = diff[WIDTH-1:0];
        alu_flags[FLAG_L] = diff[WIDTH];
        alu_flags[FLAG_N] = ($signed(s1_a) < $signed(s1_b));
        alu_flags[FLAG_Z] = (s1_a == s1_b);
      end
      OP_AND: begin
        alu_res           = s1_a & s1_b;
        alu_wr            = 1'b1;
        alu_flags[FLAG_Z] = ((s1_a & s1_b) == '0);
      end
      OP_OR: begin
        alu_res           = s1_a | s1_b;
        alu_wr            = 1'b1;
        alu_flags[FLAG_Z] = ((s1_a | s1_b) == '0);
      end
      OP_XOR: begin
        alu_res           = s1_a ^ s1_b;
        alu_wr            = 1'b1;
        alu_flags[FLAG_Z] = ((s1_a ^ s1_b) == '0);
      end
      OP_MOV: begin
        alu_res = s1_b;
        alu_wr  = 1'b1;
      end
      OP_LSH: begin
        // B's sign bit picks the direction: clear = left, set = logical right
        alu_res           = s1_b[WIDTH-1] ? (s1_a >> 1) : (s1_a << 1);
        alu_wr            = 1'b1;
        alu_flags[FLAG_Z] = (alu_res == '0);
      end
      default: begin
        alu_res = '0;
      end
    endcase
  end

  // The op in stage 1 writes back on the same edge that captures the next op,
  // so its ALU output is forwarded in place of the stale array value.
  assign a_byp = s1_valid && alu_wr && (s1_dest == RdestRegLoc);
  assign b_byp = s1_valid && alu_wr && (s1_dest == RsrcRegLoc);
  assign op_a  = a_byp ? alu_res : regs[RdestRegLoc];
  assign op_b  = Imm_s ? Imm : (b_byp ? alu_res : regs[RsrcRegLoc]);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      s1_valid  <= 1'b0;
      s1_dest   <= '0;
      s1_op     <= '0;
      s1_a      <= '0;
      s1_b      <= '0;
      Out_valid <= 1'b0;
      Result    <= '0;
      Flags     <= '0;
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      s1_valid  <= In_valid;
      Out_valid <= s1_valid;
      if (In_valid) begin
        s1_dest <= RdestRegLoc;
        s1_op   <= OpCode;
        s1_a    <= op_a;
        s1_b    <= op_b;
      end
      if (s1_valid) begin
        Result <= alu_res;
        Flags  <= alu_flags;
        if (alu_wr) begin
          regs[s1_dest] <= alu_res;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_regfile_alu_pipe.sv
// ============================================================================
// Module   : tb_regfile_alu_pipe
// Brief    : Scoreboard bench for regfile_alu_pipe against an in-order ISA model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_regfile_alu_pipe;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        In_valid = 1'b0;
  logic [3:0]  RdestRegLoc = '0;
  logic [3:0]  RsrcRegLoc = '0;
  logic        Imm_s = 1'b0;
  logic [15:0] Imm = '0;
  logic [4:0]  OpCode = '0;
  logic        Out_valid;
  logic [15:0] Result;
  logic [4:0]  Flags;

  regfile_alu_pipe #(.WIDTH(16), .REG_ADDR_W(4)) dut (
    .Clk(Clk), .Rst(Rst), .In_valid(In_valid), .RdestRegLoc(RdestRegLoc),
    .RsrcRegLoc(RsrcRegLoc), .Imm_s(Imm_s), .Imm(Imm), .OpCode(OpCode),
    .Out_valid(Out_valid), .Result(Result), .Flags(Flags)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] res;
    logic [4:0]  flg;
    int          due;
    bit          nop;
  } exp_t;

  exp_t        q[$];
  int          n_vec = 0;
  int          n_mis = 0;

  // Architectural model: registers and flags updated strictly in program order.
  int          mregs [16];
  logic [4:0]  mflags = '0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_mis++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  function automatic int to_signed16(input int v);
    return (v >= 32768) ? v - 65536 : v;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 16; i++) mregs[i] = 0;
    mflags = '0;
  endtask

  task automatic issue(input bit v, input logic [4:0] op, input int d, input int s,
                       input bit ims, input logic [15:0] imm);
    int a, b, sa, sb, r, sr;
    exp_t e;
    In_valid    = v;
    OpCode      = op;
    RdestRegLoc = d[3:0];
    RsrcRegLoc  = s[3:0];
    Imm_s       = ims;
    Imm         = imm;
    if (v) begin
      a  = mregs[d];
      b  = ims ? int'(imm) : mregs[s];
      sa = to_signed16(a);
      sb = to_signed16(b);
      r  = 0;
      case (op)
        5'h00: begin
          r = (a + b) % 65536; sr = sa + sb;
          mflags[0] = (a + b) > 65535;
          mflags[2] = (sr > 32767) || (sr < -32768);
          mflags[3] = (r == 0);
        end
        5'h01: begin
          r = (a - b + 65536) % 65536; sr = sa - sb;
          mflags[0] = (a < b);
          mflags[2] = (sr > 32767) || (sr < -32768);
          mflags[3] = (r == 0);
        end
        5'h02: begin
          r = (a - b + 65536) % 65536;
          mflags[1] = (a < b);
          mflags[4] = (sa < sb);
          mflags[3] = (a == b);
        end
        5'h03: begin r = a & b; mflags[3] = (r == 0); end
        5'h04: begin r = a | b; mflags[3] = (r == 0); end
        5'h05: begin r = a ^ b; mflags[3] = (r == 0); end
        5'h06: r = b;
        5'h07: begin
          r = (b >= 32768) ? a / 2 : (a * 2) % 65536;
          mflags[3] = (r == 0);
        end
        default: r = 0;
      endcase
      if (op <= 5'h07 && op != 5'h02) mregs[d] = r;
      e.res = r[15:0];
      e.flg = mflags;
      e.due = cyc + 2;
      e.nop = (op > 5'h07);
      q.push_back(e);
    end
    @(posedge Clk); #1;
    In_valid = 1'b0;
  endtask

  task automatic do_reset();
    Rst         = 1'b1;
    In_valid    = 1'b1;
    OpCode      = 5'h06;
    RdestRegLoc = 4'd5;
    Imm_s       = 1'b1;
    Imm         = 16'hBEEF;
    @(posedge Clk); #1;
    Rst      = 1'b0;
    In_valid = 1'b0;
    q.delete();
    model_clear();
    chk("reset_out_valid", {31'b0, Out_valid}, 32'd0);
    chk("reset_result", {16'b0, Result}, 32'd0);
    chk("reset_flags", {27'b0, Flags}, 32'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) issue(1'b0, 5'h00, 0, 0, 1'b0, 16'h0);
  endtask

  // Monitor: every retirement must match the oldest outstanding op, on time.
  always @(negedge Clk) begin
    exp_t e;
    if (!Rst) begin
      if (Out_valid) begin
        if (q.size() == 0) begin
          chk("spurious_out_valid", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk("retire_latency", cyc, e.due);
          if (!e.nop) chk("result", {16'b0, Result}, {16'b0, e.res});
          chk("flags", {27'b0, Flags}, {27'b0, e.flg});
        end
      end else if (q.size() > 0 && cyc >= q[0].due) begin
        e = q.pop_front();
        chk("missing_out_valid", 32'd0, 32'd1);
      end
    end
  end

  initial begin
    int op_sel, d, s;
    logic [4:0] op;
    model_clear();
    Rst = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    Rst = 1'b0;
    chk("init_out_valid", {31'b0, Out_valid}, 32'd0);
    chk("init_result", {16'b0, Result}, 32'd0);
    chk("init_flags", {27'b0, Flags}, 32'd0);

    issue(1, 5'h00, 1, 0, 1, 16'd5);
    issue(1, 5'h00, 2, 0, 1, 16'd7);
    idle(3);

    do_reset();
    issue(1, 5'h00, 1, 0, 1, 16'd5);
    issue(1, 5'h00, 1, 1, 0, 16'h0);
    issue(1, 5'h04, 1, 0, 1, 16'h0);
    idle(3);

    issue(1, 5'h06, 3, 0, 1, 16'hFFFF);
    issue(1, 5'h00, 3, 0, 1, 16'h0001);
    issue(1, 5'h01, 3, 0, 1, 16'h0001);
    idle(3);

    issue(1, 5'h06, 4, 0, 1, 16'h7FFF);
    issue(1, 5'h00, 4, 0, 1, 16'h0001);
    issue(1, 5'h02, 4, 0, 1, 16'h0001);
    issue(1, 5'h04, 4, 0, 1, 16'h0000);
    idle(3);

    issue(1, 5'h06, 5, 0, 1, 16'h1234);
    do_reset();
    idle(3);
    issue(1, 5'h04, 5, 0, 1, 16'h0000);
    idle(3);

    issue(1, 5'h06, 1, 0, 1, 16'h8001);
    issue(1, 5'h1F, 1, 0, 1, 16'h0000);
    issue(1, 5'h07, 1, 0, 1, 16'h8000);
    issue(1, 5'h07, 1, 1, 1, 16'h0001);
    idle(3);

    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        do_reset();
      end else begin
        op_sel = $urandom_range(0, 9);
        if (op_sel < 8)       op = op_sel[4:0];
        else if (op_sel == 8) op = 5'h1F;
        else                  op = 5'($urandom_range(8, 30));
        d = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 3);
        s = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 3);
        issue($urandom_range(0, 4) != 0, op, d, s, 1'($urandom_range(0, 1)), 16'($urandom));
      end
    end

    idle(3);
    for (int r = 0; r < 16; r++) issue(1, 5'h04, r, 0, 1, 16'h0000);
    idle(4);
    chk("queue_drained", q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

`default_nettype wire
